// File: rtl/load_use_hazard_unit.sv
// rtl/load_use_hazard_unit.sv - load-use hazard detector with per-register pending-load scoreboard
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module load_use_hazard_unit #(
  parameter int NUM_REGS     = 16,
  parameter int ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter int LOAD_LATENCY = 2,
  parameter int WORD         = 32,
  localparam int CNT_W       = $clog2(LOAD_LATENCY + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ex_is_valid_i,
  input  logic                  ex_mem_read_en_i,
  input  logic                  ex_reg_write_en_i,
  input  logic [ADDR_WIDTH-1:0] ex_reg_dest_addr_i,
  input  logic                  id_is_valid_i,
  input  logic                  id_src1_used_i,
  input  logic                  id_src2_used_i,
  input  logic [ADDR_WIDTH-1:0] id_src1_addr_i,
  input  logic [ADDR_WIDTH-1:0] id_src2_addr_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic                  stall_state_o,
  output logic [WORD-1:0]       perf_stall_cnt_o
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LOAD_LATENCY);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic             load_capture;
  logic             hz;
  logic             stall_req;
  state_t           state_q;
  state_t           state_d;

  // A flushed load never reaches memory, so it must not create a pending entry.
  assign load_capture = ex_is_valid_i && ex_mem_read_en_i && ex_reg_write_en_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (load_capture && (ex_reg_dest_addr_i == ADDR_WIDTH'(r))) begin
          cnt_q[r] <= LAT_CNT;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  assign hz = id_is_valid_i &&
              ((id_src1_used_i && (cnt_q[id_src1_addr_i] != '0)) ||
               (id_src2_used_i && (cnt_q[id_src2_addr_i] != '0)));

  assign stall_req = hz && !flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = stall_req ? STALL : RUN;
      STALL:   state_d = stall_req ? STALL : RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_o       = stall_req;
    bubble_o      = stall_req;
    stall_state_o = (state_q == STALL);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [WORD-1:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_q <= '0;
    end else if (stall_req && (perf_q != '1)) begin
      perf_q <= perf_q + WORD'(1);
    end
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// tb/tb_load_use_hazard_unit.sv - directed scoreboard bench for load_use_hazard_unit
// Expected perf count follows HAZARD_PERF_CNT_EN when the bench is built with it.
module tb_load_use_hazard_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ex_is_valid_i;
  logic        ex_mem_read_en_i;
  logic        ex_reg_write_en_i;
  logic [3:0]  ex_reg_dest_addr_i;
  logic        id_is_valid_i;
  logic        id_src1_used_i;
  logic        id_src2_used_i;
  logic [3:0]  id_src1_addr_i;
  logic [3:0]  id_src2_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic        bubble_o;
  logic        stall_state_o;
  logic [31:0] perf_stall_cnt_o;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        state;
    logic [31:0] perf;
  } obs_t;

  obs_t        exp_q[$];
  string       tag_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_perf = '0;
  logic [31:0] exp_six;

  load_use_hazard_unit dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .ex_is_valid_i      (ex_is_valid_i),
    .ex_mem_read_en_i   (ex_mem_read_en_i),
    .ex_reg_write_en_i  (ex_reg_write_en_i),
    .ex_reg_dest_addr_i (ex_reg_dest_addr_i),
    .id_is_valid_i      (id_is_valid_i),
    .id_src1_used_i     (id_src1_used_i),
    .id_src2_used_i     (id_src2_used_i),
    .id_src1_addr_i     (id_src1_addr_i),
    .id_src2_addr_i     (id_src2_addr_i),
    .flush_i            (flush_i),
    .stall_o            (stall_o),
    .bubble_o           (bubble_o),
    .stall_state_o      (stall_state_o),
    .perf_stall_cnt_o   (perf_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic ev, input logic mr, input logic rw, input logic [3:0] rd,
                       input logic iv, input logic u1, input logic u2,
                       input logic [3:0] s1, input logic [3:0] s2, input logic fl);
    ex_is_valid_i      = ev;
    ex_mem_read_en_i   = mr;
    ex_reg_write_en_i  = rw;
    ex_reg_dest_addr_i = rd;
    id_is_valid_i      = iv;
    id_src1_used_i     = u1;
    id_src2_used_i     = u2;
    id_src1_addr_i     = s1;
    id_src2_addr_i     = s2;
    flush_i            = fl;
  endtask

  // One cycle: inputs already driven, expectation queued, compared at negedge.
  task automatic check_cycle(input string tag, input logic es, input logic est);
    obs_t  e;
    obs_t  o;
    string t;
    exp_q.push_back('{stall: es, bubble: es, state: est, perf: exp_perf});
    tag_q.push_back(tag);
    @(negedge clk_i);
    o = '{stall: stall_o, bubble: bubble_o, state: stall_state_o, perf: perf_stall_cnt_o};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed stall/bubble/state/perf=%h required %h", t, o, e);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (es) exp_perf = exp_perf + 32'd1;
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input string tag, input logic [3:0] rd, input logic est);
    drive(1'b1, 1'b1, 1'b1, rd, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check_cycle(tag, 1'b0, est);
  endtask

  task automatic idle(input string tag, input logic est);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check_cycle(tag, 1'b0, est);
  endtask

  task automatic use_src(input string tag, input logic u1, input logic [3:0] s1,
                         input logic u2, input logic [3:0] s2, input logic fl,
                         input logic es, input logic est);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, u1, u2, s1, s2, fl);
    check_cycle(tag, es, est);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    idle("reset_state", 1'b0);

    // Single-source load-use: two stall cycles, state lags by one
    load("t1_load_r3", 4'd3, 1'b0);
    use_src("t1_stall0", 1'b1, 4'd3, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    use_src("t1_stall1", 1'b1, 4'd3, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1);
    use_src("t1_issue",  1'b1, 4'd3, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    idle("t1_run", 1'b0);

    // Independent register and unused source 2 pointing at the load target
    load("t2_load_r3", 4'd3, 1'b0);
    use_src("t2_indep0", 1'b1, 4'd5, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    use_src("t2_indep1", 1'b1, 4'd5, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    idle("t2_idle", 1'b0);

    // Load without register write does not register a pending result
    drive(1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check_cycle("nowrite_load", 1'b0, 1'b0);
    use_src("nowrite_use", 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Two back-to-back loads, both sources pending: stall until later one drains
    load("t3_load_r3", 4'd3, 1'b0);
    load("t3_load_r7", 4'd7, 1'b0);
    use_src("t3_both",   1'b1, 4'd3, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    use_src("t3_r7only", 1'b1, 4'd3, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
    use_src("t3_issue",  1'b1, 4'd3, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1);
    idle("t3_run", 1'b0);

    // Flush suppresses the stall but scoreboard keeps decrementing
    load("t4_load_r3", 4'd3, 1'b0);
    use_src("t4_flush",   1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    use_src("t4_residue", 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    use_src("t4_issue",   1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle("t4_run", 1'b0);

    // Flush in the middle of a stall forces the FSM back to RUN
    load("t4b_load_r3", 4'd3, 1'b0);
    use_src("t4b_stall", 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    use_src("t4b_flush", 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    use_src("t4b_after", 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Flushed load is never captured
    drive(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    check_cycle("flushed_load", 1'b0, 1'b0);
    use_src("flushed_use", 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stall, with a load presented during reset that must not be captured
    load("t5_load_r3", 4'd3, 1'b0);
    use_src("t5_stall", 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    reset_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
    @(posedge clk_i);
    #1;
    reset_i  = 1'b0;
    exp_perf = '0;
    use_src("t5_after_reset", 1'b1, 4'd3, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);

    // Three load-use pairs of two stalls each
    for (int p = 0; p < 3; p++) begin
      logic [3:0] r;
      r = 4'(2 * p + 2);
      load($sformatf("t6_load%0d", p), r, 1'b0);
      use_src($sformatf("t6_stall0_%0d", p), 1'b0, 4'd0, 1'b1, r, 1'b0, 1'b1, 1'b0);
      use_src($sformatf("t6_stall1_%0d", p), 1'b0, 4'd0, 1'b1, r, 1'b0, 1'b1, 1'b1);
      use_src($sformatf("t6_issue_%0d", p),  1'b0, 4'd0, 1'b1, r, 1'b0, 1'b0, 1'b1);
    end
    idle("t6_idle", 1'b0);

`ifdef HAZARD_PERF_CNT_EN
    exp_six = 32'd6;
`else
    exp_six = 32'd0;
`endif
    @(negedge clk_i);
    n_cmp++;
    assert (perf_stall_cnt_o === exp_six) else begin
      n_fail++;
      $error("FAIL t6_perf_total: observed %0d required %0d", perf_stall_cnt_o, exp_six);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
